// File: rtl/debug_bus_responder.sv
// Debug-harness memory-bus slave: stands in for RAM so the core can be single-stepped on the board.
// Answers with programmable wait states, serves shifted stimulus on reads, folds writes into a signature.
module debug_bus_responder #(
  parameter int ADDRESS_SIZE  = 15,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_IRQ       = 2,
  parameter int WAIT_BITS     = 4,
  parameter int IRQ_PULSE     = 0,
  parameter int DISPLAY_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      strobe,
  input  logic [DATA_WIDTH/8-1:0]   writeEnable,
  input  logic [ADDRESS_SIZE-1:0]   address,
  input  logic [DATA_WIDTH-1:0]     dataWrite,
  output logic [DATA_WIDTH-1:0]     dataRead,
  output logic                      ready,
  input  logic                      stimIn,
  input  logic [WAIT_BITS-1:0]      waitStates,
  input  logic [1:0]                displaySel,
  output logic [NUM_IRQ-1:0]        interruptReq,
  output logic [DISPLAY_WIDTH-1:0]  display
);

  localparam int NB = DATA_WIDTH / 8;

  // Handshake: the master raises strobe and holds it until ready (a one-cycle
  // pulse) or until it gives up by dropping strobe while we are still waiting.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t                    state, next_state;
  logic [WAIT_BITS-1:0]      cnt, cnt_next;
  logic                      capture;
  logic                      abort_evt;

  logic [ADDRESS_SIZE-1:0]   addr_q;
  logic [NB-1:0]             we_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     read_q;
  logic [DATA_WIDTH-1:0]     drain;
  logic [DATA_WIDTH-1:0]     sig;
  logic [DATA_WIDTH-1:0]     masked;
  logic [15:0]               txn_count;
  logic [3:0]                abort_count;
  logic [7:0]                disp_src;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    abort_evt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (strobe) begin
          capture    = 1'b1;
          cnt_next   = waitStates;
          next_state = (waitStates == '0) ? ST_RESPOND : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!strobe) begin
          next_state = ST_IDLE;
          abort_evt  = 1'b1;
        end else if (cnt == WAIT_BITS'(1)) begin
          next_state = ST_RESPOND;
        end else begin
          cnt_next = cnt - WAIT_BITS'(1);
        end
      end
      ST_RESPOND: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Request capture; the read snapshot takes drain before this edge's shift.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      read_q  <= '0;
    end else if (capture) begin
      addr_q  <= address;
      we_q    <= writeEnable;
      wdata_q <= dataWrite;
      read_q  <= drain;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) drain <= '0;
    else        drain <= {drain[DATA_WIDTH-2:0], stimIn};
  end

  always_comb begin
    masked = '0;
    for (int b = 0; b < NB; b++) begin
      if (we_q[b]) masked[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  // Signature and counters commit on the edge that closes the RESPOND cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sig         <= '0;
      txn_count   <= '0;
      abort_count <= '0;
    end else begin
      if (state == ST_RESPOND) begin
        txn_count <= txn_count + 16'd1;
        if (we_q != '0)
          sig <= {sig[7:0], sig[DATA_WIDTH-1:8]} ^ masked ^ DATA_WIDTH'(addr_q);
      end
      if (abort_evt) abort_count <= abort_count + 4'd1;
    end
  end

  assign ready    = (state == ST_RESPOND);
  assign dataRead = (ready && we_q == '0) ? read_q : '0;

  generate
    if (IRQ_PULSE != 0) begin : g_pulse
      logic [NUM_IRQ-1:0] irq_prev;
      always_ff @(posedge clock) begin
        if (!reset) begin
          irq_prev     <= '0;
          interruptReq <= '0;
        end else begin
          irq_prev     <= drain[NUM_IRQ-1:0];
          interruptReq <= drain[NUM_IRQ-1:0] & ~irq_prev;
        end
      end
    end else begin : g_level
      always_ff @(posedge clock) begin
        if (!reset) interruptReq <= '0;
        else        interruptReq <= drain[NUM_IRQ-1:0];
      end
    end
  endgenerate

  always_comb begin
    disp_src = 8'h00;
    unique case (displaySel)
      2'b00: disp_src = sig[7:0];
      2'b01: disp_src = txn_count[7:0];
      2'b10: disp_src = {abort_count, state, ready, strobe};
      2'b11: disp_src = drain[7:0];
      default: disp_src = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) display <= '0;
    else        display <= disp_src[DISPLAY_WIDTH-1:0];
  end

endmodule
